// File: rtl/morse_entry_ctrl.sv
// Morse key entry controller: debounced buttons build a 5-symbol code, a decoder handshake turns it into a buffered character.
// Latency: sync(2) + DEB_CYCLES + 1 cycles from press to event; decoder wait is bounded by ACK_TIMEOUT; lower-priority same-cycle events are dropped.
module morse_entry_ctrl #(
    parameter int DEB_CYCLES  = 20,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       short_n,
    input  logic       long_n,
    input  logic       decode,
    input  logic       back,
    input  logic       clear_all,
    output logic       dec_req,
    output logic [4:0] dec_code,
    output logic [2:0] dec_len,
    input  logic       dec_ack,
    input  logic [7:0] dec_char,
    input  logic       dec_err,
    output logic       buf_we,
    output logic [2:0] buf_addr,
    output logic [7:0] buf_wdata,
    output logic       clr_buf,
    output logic [3:0] char_count,
    output logic       full,
    output logic       err,
    output logic [4:0] sym_leds
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ENTRY, REQ, WRITE} state_t;

    // Bit order: 0 short, 1 long, 2 decode, 3 back, 4 clear_all; all normalised to 1 = pressed.
    logic [4:0]    btn_raw;
    logic [4:0]    sync1, sync2, level, armed, evt;
    logic [1:0]    fill;
    logic [DW-1:0] deb_cnt [5];

    assign btn_raw = {clear_all, back, decode, ~long_n, ~short_n};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            fill  <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            fill  <= {fill[0], 1'b1};
        end
    end

    // A button must be seen released (after the synchronizer has filled) before its presses count,
    // so a key held through reset stays silent until it is let go and pressed again.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level <= '0;
            armed <= '0;
            evt   <= '0;
            for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
        end else begin
            evt <= '0;
            for (int i = 0; i < 5; i++) begin
                if (fill[1] && !sync2[i]) armed[i] <= 1'b1;
                if (sync2[i] == level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_cnt[i] <= '0;
                    level[i]   <= sync2[i];
                    evt[i]     <= sync2[i] & armed[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic ev_clr, ev_back, ev_dec, ev_short, ev_long, ev_sym;

    assign ev_clr   = evt[4];
    assign ev_back  = evt[3] & ~evt[4];
    assign ev_dec   = evt[2] & ~(|evt[4:3]);
    assign ev_short = evt[0] & ~(|evt[4:2]);
    assign ev_long  = evt[1] & ~(|evt[4:2]) & ~evt[0];
    assign ev_sym   = ev_short | ev_long;

    state_t        state, state_n;
    logic          dec_req_n, buf_we_n, clr_n, err_n;
    logic [4:0]    code_n;
    logic [2:0]    len_n, addr_n;
    logic [3:0]    count_n;
    logic [7:0]    wdata_n;
    logic [TW-1:0] timer, timer_n;

    assign full     = (char_count == 4'd8);
    assign sym_leds = dec_code;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            dec_req    <= 1'b0;
            dec_code   <= '0;
            dec_len    <= '0;
            char_count <= '0;
            err        <= 1'b0;
            buf_we     <= 1'b0;
            buf_addr   <= '0;
            buf_wdata  <= 8'hFF;
            clr_buf    <= 1'b0;
            timer      <= '0;
        end else begin
            state      <= state_n;
            dec_req    <= dec_req_n;
            dec_code   <= code_n;
            dec_len    <= len_n;
            char_count <= count_n;
            err        <= err_n;
            buf_we     <= buf_we_n;
            buf_addr   <= addr_n;
            buf_wdata  <= wdata_n;
            clr_buf    <= clr_n;
            timer      <= timer_n;
        end
    end

    always_comb begin
        state_n   = state;
        dec_req_n = dec_req;
        code_n    = dec_code;
        len_n     = dec_len;
        count_n   = char_count;
        err_n     = err;
        buf_we_n  = 1'b0;
        addr_n    = buf_addr;
        wdata_n   = buf_wdata;
        clr_n     = 1'b0;
        timer_n   = timer;

        if (ev_clr) begin
            state_n   = IDLE;
            dec_req_n = 1'b0;
            code_n    = '0;
            len_n     = '0;
            count_n   = '0;
            err_n     = 1'b0;
            clr_n     = 1'b1;
        end else begin
            case (state)
                IDLE, ENTRY: begin
                    if (ev_sym) begin
                        if (dec_len == 3'd5) begin
                            err_n = 1'b1;
                        end else begin
                            code_n[dec_len] = ev_long;
                            len_n           = dec_len + 3'd1;
                            state_n         = ENTRY;
                        end
                    end else if (ev_back) begin
                        if (state == ENTRY) begin
                            len_n         = dec_len - 3'd1;
                            code_n[len_n] = 1'b0;
                            if (len_n == 3'd0) state_n = IDLE;
                        end else if (char_count != 4'd0) begin
                            // Erase the last character by writing a blank pattern over it.
                            buf_we_n = 1'b1;
                            addr_n   = 3'(char_count - 4'd1);
                            wdata_n  = 8'hFF;
                            count_n  = char_count - 4'd1;
                        end
                    end else if (ev_dec && state == ENTRY) begin
                        if (full) begin
                            err_n   = 1'b1;
                            code_n  = '0;
                            len_n   = '0;
                            state_n = IDLE;
                        end else begin
                            dec_req_n = 1'b1;
                            timer_n   = '0;
                            state_n   = REQ;
                        end
                    end
                end
                REQ: begin
                    if (dec_ack) begin
                        dec_req_n = 1'b0;
                        if (dec_err) begin
                            err_n   = 1'b1;
                            code_n  = '0;
                            len_n   = '0;
                            state_n = IDLE;
                        end else begin
                            // Write strobe is registered so it is visible exactly during WRITE.
                            buf_we_n = 1'b1;
                            addr_n   = char_count[2:0];
                            wdata_n  = dec_char;
                            state_n  = WRITE;
                        end
                    end else if (timer == TO_LAST) begin
                        dec_req_n = 1'b0;
                        err_n     = 1'b1;
                        code_n    = '0;
                        len_n     = '0;
                        state_n   = IDLE;
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
                WRITE: begin
                    count_n = char_count + 4'd1;
                    code_n  = '0;
                    len_n   = '0;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule
